assoc_cache: RTL and testbench

Parametrised N-way set-associative, write-through, no-write-allocate cache with a built-in miss handler. It replaces the fixed 2-way/64-set I/D cache pair and is instantiated once per port (instruction and data) between the pipeline and the 16-bit memory. On a miss it fills the block autonomously as a burst of single-word reads. It supports true-LRU replacement for any power-of-2 way count, plus whole-cache flush.

---
 rtl/assoc_cache.sv | 236 +++++++++++++++++++++++
 tb/tb_assoc_cache.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/assoc_cache.sv
// assoc_cache: N-way set-associative, write-through, no-write-allocate cache.
// Load misses fill the whole block as a burst of single-word memory reads.
// Stores always go to memory; a store hit also updates the cached word.
// Replacement is true LRU, kept as a per-set age per way.
module assoc_cache #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int WAYS      = 2,
  parameter int SETS      = 64,
  parameter int BLK_WORDS = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic              flush,
  output logic              ready,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  localparam int WO    = $clog2(BLK_WORDS);
  localparam int IX    = $clog2(SETS);
  localparam int TAG_W = ADDR_W - 1 - WO - IX;
  localparam int WW    = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [WO-1:0]   cnt_q, cnt_d;
  logic [WW-1:0]   victim_q, victim_d;

  // Storage: data and tags are qualified by valid, so only valid and age reset.
  logic [DATA_W-1:0] data_q  [WAYS][SETS][BLK_WORDS];
  logic [TAG_W-1:0]  tag_q   [WAYS][SETS];
  logic [WAYS-1:0]   valid_q [SETS];
  logic [WW-1:0]     age_q   [SETS][WAYS];

  // Request address fields; the request is held stable until ready.
  logic [WO-1:0]    req_off;
  logic [IX-1:0]    req_idx;
  logic [TAG_W-1:0] req_tag;
  assign req_off = req_addr[WO:1];
  assign req_idx = req_addr[WO+IX:WO+1];
  assign req_tag = req_addr[ADDR_W-1:WO+IX+1];

  // Array update controls produced by the control logic.
  logic              data_we;
  logic [WW-1:0]     data_way;
  logic [WO-1:0]     data_word;
  logic [DATA_W-1:0] data_wval;
  logic              touch_en;
  logic [WW-1:0]     touch_way;
  logic              inval_en;
  logic              fill_done;
  logic              flush_all;

  logic [WAYS-1:0] hit_vec;
  logic [WW-1:0]   hit_way;
  logic            hit;
  logic [WW-1:0]   victim_sel;
  logic            found_inv;

  // Tag compare across all ways of the indexed set.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    hit_vec = '0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[req_idx][w] && (tag_q[w][req_idx] == req_tag)) begin
        hit_vec[w] = 1'b1;
        hit_way    = WW'(w);
      end
    end
  end
  assign hit = |hit_vec;

  // Victim choice: lowest-index invalid way, otherwise the oldest way.
  always_comb begin
    victim_sel = '0;
    found_inv  = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!found_inv && !valid_q[req_idx][w]) begin
        victim_sel = WW'(w);
        found_inv  = 1'b1;
      end
    end
    if (!found_inv) begin
      for (int w = 0; w < WAYS; w++) begin
        if (age_q[req_idx][w] == WW'(WAYS - 1)) victim_sel = WW'(w);
      end
    end
  end

  // Next-state and output logic of the request/miss-handler FSM.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    victim_d  = victim_q;
    ready     = 1'b0;
    rdata     = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    data_we   = 1'b0;
    data_way  = '0;
    data_word = '0;
    data_wval = '0;
    touch_en  = 1'b0;
    touch_way = '0;
    inval_en  = 1'b0;
    fill_done = 1'b0;
    flush_all = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (flush) begin
          flush_all = 1'b1;
        end else if (req_valid) begin
          if (!req_we) begin
            if (hit) begin
              ready     = 1'b1;
              rdata     = data_q[hit_way][req_idx][req_off];
              touch_en  = 1'b1;
              touch_way = hit_way;
            end else begin
              victim_d = victim_sel;
              cnt_d    = '0;
              inval_en = 1'b1;
              state_d  = S_FILL;
            end
          end else begin
            if (hit) begin
              data_we   = 1'b1;
              data_way  = hit_way;
              data_word = req_off;
              data_wval = req_wdata;
              touch_en  = 1'b1;
              touch_way = hit_way;
            end
            state_d = S_WRITE;
          end
        end
      end
      S_FILL: begin
        mem_req  = 1'b1;
        mem_addr = {req_tag, req_idx, cnt_q, 1'b0};
        if (mem_ack) begin
          data_we   = 1'b1;
          data_way  = victim_q;
          data_word = cnt_q;
          data_wval = mem_rdata;
          cnt_d     = cnt_q + 1'b1;
          if (cnt_q == WO'(BLK_WORDS - 1)) begin
            fill_done = 1'b1;
            touch_en  = 1'b1;
            touch_way = victim_q;
            state_d   = S_IDLE;
          end
        end
      end
      S_WRITE: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = req_addr & ~ADDR_W'(1);
        mem_wdata = req_wdata;
        if (mem_ack) begin
          ready   = req_valid;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state, fill word counter and latched victim way.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      victim_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      victim_q <= victim_d;
    end
  end

  // Valid bits and LRU ages; ages restart as the way index (way 0 MRU).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) age_q[s][w] <= WW'(w);
      end
    end else begin
      if (flush_all) begin
        for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
      end
      if (inval_en)  valid_q[req_idx][victim_sel] <= 1'b0;
      if (fill_done) valid_q[req_idx][victim_q]   <= 1'b1;
      if (touch_en) begin
        for (int v = 0; v < WAYS; v++) begin
          if (WW'(v) == touch_way) begin
            age_q[req_idx][v] <= '0;
          end else if (age_q[req_idx][v] < age_q[req_idx][touch_way]) begin
            age_q[req_idx][v] <= age_q[req_idx][v] + 1'b1;
          end
        end
      end
    end
  end

  // Data and tag arrays.
  // NOTE: memories are not reset; valid_q alone decides whether contents count.
  always_ff @(posedge clk) begin
    if (data_we)   data_q[data_way][req_idx][data_word] <= data_wval;
    if (fill_done) tag_q[victim_q][req_idx]             <= req_tag;
  end

  // A line is never resident in two ways of the same set.
  a_single_hit: assert property (@(posedge clk) disable iff (!rst) $onehot0(hit_vec));

endmodule

// File: tb/tb_assoc_cache.sv
// Self-checking bench for assoc_cache: a 2-way/64-set and a 4-way/16-set
// instance share one stimulus driver and a word-addressed backing memory.
// Expected behaviour comes from per-set recency lists of tags.
module tb_assoc_cache;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req_valid, req_we, flush, mem_ack;
  logic [15:0] req_addr, req_wdata, mem_rdata;
  bit          sel;

  logic        ready_a, mem_req_a, mem_we_a, ready_b, mem_req_b, mem_we_b;
  logic [15:0] rdata_a, mem_addr_a, mem_wdata_a, rdata_b, mem_addr_b, mem_wdata_b;
  logic        rv_a, rv_b, fl_a, fl_b, ack_a, ack_b;

  assign rv_a  = req_valid & ~sel;
  assign rv_b  = req_valid & sel;
  assign fl_a  = flush & ~sel;
  assign fl_b  = flush & sel;
  assign ack_a = mem_ack & ~sel;
  assign ack_b = mem_ack & sel;

  assoc_cache #(.ADDR_W(16), .DATA_W(16), .WAYS(2), .SETS(64), .BLK_WORDS(8)) dut_a (
    .clk(clk), .rst(rst), .req_valid(rv_a), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .flush(fl_a), .ready(ready_a), .rdata(rdata_a),
    .mem_req(mem_req_a), .mem_we(mem_we_a), .mem_addr(mem_addr_a),
    .mem_wdata(mem_wdata_a), .mem_rdata(mem_rdata), .mem_ack(ack_a)
  );

  assoc_cache #(.ADDR_W(16), .DATA_W(16), .WAYS(4), .SETS(16), .BLK_WORDS(8)) dut_b (
    .clk(clk), .rst(rst), .req_valid(rv_b), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .flush(fl_b), .ready(ready_b), .rdata(rdata_b),
    .mem_req(mem_req_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b),
    .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata), .mem_ack(ack_b)
  );

  logic        ready, mem_req, mem_we;
  logic [15:0] rdata, mem_addr, mem_wdata;
  assign ready     = sel ? ready_b     : ready_a;
  assign mem_req   = sel ? mem_req_b   : mem_req_a;
  assign mem_we    = sel ? mem_we_b    : mem_we_a;
  assign rdata     = sel ? rdata_b     : rdata_a;
  assign mem_addr  = sel ? mem_addr_b  : mem_addr_a;
  assign mem_wdata = sel ? mem_wdata_b : mem_wdata_a;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Backing memory and reference cache: per set, tags ordered MRU first.
  logic [15:0] refmem [32768];
  int          lru_m  [64][$];
  int          ways_m, sets_m, ix_m;

  function automatic int m_idx(input logic [15:0] a);
    return (int'(a) >> 4) % sets_m;
  endfunction

  function automatic int m_tag(input logic [15:0] a);
    return int'(a) >> (4 + ix_m);
  endfunction

  function automatic int m_find(input logic [15:0] a);
    int s = m_idx(a);
    int t = m_tag(a);
    for (int i = 0; i < lru_m[s].size(); i++) if (lru_m[s][i] == t) return i;
    return -1;
  endfunction

  function automatic void m_touch(input logic [15:0] a);
    int s = m_idx(a);
    int p = m_find(a);
    if (p >= 0) lru_m[s].delete(p);
    lru_m[s].push_front(m_tag(a));
    if (lru_m[s].size() > ways_m) void'(lru_m[s].pop_back());
  endfunction

  function automatic void m_clear();
    for (int s = 0; s < 64; s++) lru_m[s].delete();
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; req_valid = 1'b0; flush = 1'b0; mem_ack = 1'b0;
    #1;
    check("rst_ready", ready, 1'b0);
    check("rst_rdata", rdata, 16'h0);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_addr", mem_addr, 16'h0);
    check("rst_mem_wdata", mem_wdata, 16'h0);
    m_clear();
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Flush in IDLE, optionally with a load presented in the same cycle.
  task automatic do_flush(input bit with_req, input logic [15:0] addr);
    @(negedge clk);
    flush = 1'b1; req_valid = with_req; req_we = 1'b0; req_addr = addr; mem_ack = 1'b0;
    #1;
    check("flush_ready", ready, 1'b0);
    check("flush_mem_req", mem_req, 1'b0);
    m_clear();
  endtask

  // One complete request. abort_after>0 resets the block after that many fill acks.
  task automatic run_op(input bit we, input logic [15:0] addr, input logic [15:0] wd,
                        input int abort_after, input bit flush_fill);
    bit          hit;
    bit          ack;
    int          acks;
    int          waits;
    logic [15:0] base;
    logic [15:0] fa;
    hit   = (m_find(addr) >= 0);
    acks  = 0;
    waits = 0;
    base  = addr & 16'hFFF0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
    mem_ack = 1'b0; flush = 1'b0;
    #1;
    if (!we && hit) begin
      check("ld_hit_ready", ready, 1'b1);
      check("ld_hit_data", rdata, refmem[addr[15:1]]);
      check("ld_hit_mem_req", mem_req, 1'b0);
      m_touch(addr);
    end else begin
      check("first_ready", ready, 1'b0);
      check("first_rdata", rdata, 16'h0);
      check("first_mem_req", mem_req, 1'b0);
      if (we) begin
        if (hit) m_touch(addr);
        ack = 1'b0;
        while (!ack) begin
          @(negedge clk);
          mem_ack = 1'b0;
          #1;
          check("wr_mem_req", mem_req, 1'b1);
          if (mem_req !== 1'b1) break;
          check("wr_mem_we", mem_we, 1'b1);
          check("wr_mem_addr", mem_addr, addr & 16'hFFFE);
          check("wr_mem_wdata", mem_wdata, wd);
          ack = (waits >= 3) || ($urandom_range(0, 2) != 0);
          waits++;
          mem_ack = ack;
          if (ack) refmem[addr[15:1]] = wd;
          #1;
          check("wr_ready", ready, ack);
        end
      end else begin
        while (acks < 8) begin
          @(negedge clk);
          mem_ack = 1'b0;
          flush = flush_fill;
          #1;
          check("fill_mem_req", mem_req, 1'b1);
          if (mem_req !== 1'b1) break;
          fa = base + 16'(2 * acks);
          check("fill_mem_we", mem_we, 1'b0);
          check("fill_mem_addr", mem_addr, fa);
          ack = (waits >= 3) || ($urandom_range(0, 2) != 0);
          waits++;
          mem_ack = ack;
          mem_rdata = ack ? refmem[fa[15:1]] : 16'($urandom);
          #1;
          check("fill_ready", ready, 1'b0);
          if (ack) begin
            acks++;
            waits = 0;
            if (acks == abort_after) begin
              @(negedge clk);
              rst = 1'b0; mem_ack = 1'b0; flush = 1'b0;
              #1;
              check("abort_mem_req", mem_req, 1'b0);
              check("abort_ready", ready, 1'b0);
              m_clear();
              @(negedge clk);
              rst = 1'b1; req_valid = 1'b0;
              return;
            end
          end
        end
        @(negedge clk);
        mem_ack = 1'b0; flush = 1'b0;
        #1;
        check("post_fill_mem_req", mem_req, 1'b0);
        check("ld_miss_ready", ready, 1'b1);
        check("ld_miss_data", rdata, refmem[addr[15:1]]);
        m_touch(addr);
      end
    end
    // Idle cycle with a stray ack that must be ignored.
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b0; req_addr = 16'($urandom);
    mem_ack = 1'($urandom_range(0, 1)); mem_rdata = 16'($urandom);
    #1;
    check("idle_ready", ready, 1'b0);
    check("idle_mem_req", mem_req, 1'b0);
  endtask

  task automatic random_phase(input int n);
    for (int k = 0; k < n; k++) begin
      int          r;
      int          t;
      logic [15:0] a;
      r = $urandom_range(0, 99);
      t = (int'($urandom_range(0, 4)) * 37) % (1 << (12 - ix_m));
      a = 16'(t << (4 + ix_m)) | 16'($urandom_range(0, 2) << 4) | 16'($urandom_range(0, 15));
      if (r < 55)      run_op(1'b0, a, 16'h0, 0, 1'b0);
      else if (r < 90) run_op(1'b1, a, 16'($urandom), 0, 1'b0);
      else if (r < 96) begin
        do_flush(1'b1, a);
        run_op(1'b0, a, 16'h0, 0, 1'b0);
      end else         run_op(1'b0, a, 16'h0, 0, 1'b1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; sel = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_wdata = '0; flush = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    ways_m = 2; sets_m = 64; ix_m = 6;
    for (int i = 0; i < 32768; i++) refmem[i] = 16'($urandom);
    m_clear();
    do_reset();

    // Basic fill and hit.
    run_op(1'b0, 16'h1234, 16'h0, 0, 1'b0);
    run_op(1'b0, 16'h123A, 16'h0, 0, 1'b0);
    // LRU in set 0: A, B, touch A, C evicts B.
    run_op(1'b0, 16'h0000, 16'h0, 0, 1'b0);
    run_op(1'b0, 16'h0400, 16'h0, 0, 1'b0);
    run_op(1'b0, 16'h0002, 16'h0, 0, 1'b0);
    run_op(1'b0, 16'h0800, 16'h0, 0, 1'b0);
    run_op(1'b0, 16'h0000, 16'h0, 0, 1'b0);
    run_op(1'b0, 16'h0400, 16'h0, 0, 1'b0);
    // Store hit, store miss.
    run_op(1'b1, 16'h1236, 16'h5A5A, 0, 1'b0);
    run_op(1'b0, 16'h1236, 16'h0, 0, 1'b0);
    run_op(1'b1, 16'h2000, 16'hC3C3, 0, 1'b0);
    run_op(1'b0, 16'h2000, 16'h0, 0, 1'b0);
    // Reset after the third fill ack, then a full refill.
    run_op(1'b0, 16'h3456, 16'h0, 3, 1'b0);
    run_op(1'b0, 16'h3456, 16'h0, 0, 1'b0);
    // Flush with a pending request, then flush ignored during a fill.
    run_op(1'b0, 16'h1234, 16'h0, 0, 1'b0);
    run_op(1'b0, 16'h4000, 16'h0, 0, 1'b0);
    do_flush(1'b1, 16'h1234);
    run_op(1'b0, 16'h1234, 16'h0, 0, 1'b0);
    run_op(1'b0, 16'h4000, 16'h0, 0, 1'b0);
    run_op(1'b0, 16'h6000, 16'h0, 0, 1'b1);
    run_op(1'b0, 16'h6000, 16'h0, 0, 1'b0);
    random_phase(200);

    // 4-way, 16-set instance: reuse 0,1,2,3,0,4 evicts tag 1.
    sel = 1'b1; ways_m = 4; sets_m = 16; ix_m = 4;
    do_reset();
    run_op(1'b0, 16'h0000, 16'h0, 0, 1'b0);
    run_op(1'b0, 16'h0100, 16'h0, 0, 1'b0);
    run_op(1'b0, 16'h0200, 16'h0, 0, 1'b0);
    run_op(1'b0, 16'h0300, 16'h0, 0, 1'b0);
    run_op(1'b0, 16'h0000, 16'h0, 0, 1'b0);
    run_op(1'b0, 16'h0400, 16'h0, 0, 1'b0);
    run_op(1'b0, 16'h0300, 16'h0, 0, 1'b0);
    run_op(1'b0, 16'h0100, 16'h0, 0, 1'b0);
    random_phase(150);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
